// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding,
// default geometry and address-field width helpers.
package icache_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_REFILL = 1'b1
  } state_t;

  localparam int NUM_LINES_DEF      = 8;
  localparam int WORDS_PER_LINE_DEF = 4;

  function automatic int off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // 30 word-address bits split into tag | index | offset
  function automatic int tag_w(input int num_lines, input int words_per_line);
    return 30 - off_w(words_per_line) - idx_w(num_lines);
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache: combinational read by index,
// one synchronous write port, valid bits cleared asynchronously.
module icache_line_array #(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 25,
  parameter int LINE_W    = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [LINE_W-1:0]    data_arr [NUM_LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/data are don't-care while the line is invalid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_arr[wr_idx]  <= wr_tag;
      data_arr[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_arr[rd_idx];
  assign rd_data  = data_arr[rd_idx];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, stall-and-refill
// of one whole line from block-wide instruction memory on a miss.
//
// state    | meaning
// S_IDLE   | lookup current proc_addr; hit returns word, miss issues refill
// S_REFILL | mem_read held, core stalled until mem_ready delivers the line
module instr_cache
  import icache_pkg::*;
#(
  parameter int NUM_LINES      = NUM_LINES_DEF,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter int BADDR_W        = 30 - off_w(WORDS_PER_LINE)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         proc_read,
  input  logic [31:0]                  proc_addr,
  output logic [31:0]                  proc_rdata,
  output logic                         proc_stall,
  output logic                         mem_read,
  output logic [BADDR_W-1:0]           mem_addr,
  input  logic [32*WORDS_PER_LINE-1:0] mem_rdata,
  input  logic                         mem_ready
);

  localparam int OFF_W  = off_w(WORDS_PER_LINE);
  localparam int IDX_W  = idx_w(NUM_LINES);
  localparam int TAG_W  = tag_w(NUM_LINES, WORDS_PER_LINE);
  localparam int LINE_W = 32 * WORDS_PER_LINE;

  state_t state, state_next;

  logic [OFF_W-1:0]  offset;
  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  refill_idx;
  logic [TAG_W-1:0]  refill_tag;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic [WORDS_PER_LINE-1:0][31:0] rd_words;
  logic              hit;
  logic              miss_start;
  logic              wr_en;
  logic              unused_byte_sel;

  assign offset          = proc_addr[2 +: OFF_W];
  assign index           = proc_addr[2+OFF_W +: IDX_W];
  assign tag             = proc_addr[31 -: TAG_W];
  assign unused_byte_sel = ^proc_addr[1:0];
  assign rd_words        = rd_data;

  icache_line_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W),
    .LINE_W    (LINE_W)
  ) u_line_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (refill_idx),
    .wr_tag   (refill_tag),
    .wr_data  (mem_rdata)
  );

  assign hit = proc_read & rd_valid & (rd_tag == tag);

  always_comb begin
    state_next = state;
    proc_stall = 1'b0;
    proc_rdata = '0;
    miss_start = 1'b0;
    wr_en      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (proc_read) begin
          if (hit) begin
            proc_rdata = rd_words[offset];
          end else begin
            proc_stall = 1'b1;
            miss_start = 1'b1;
            state_next = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        proc_stall = 1'b1;
        // Only a ready that answers our own outstanding request may write the array.
        if (mem_ready && mem_read) begin
          wr_en      = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mem_read   <= 1'b0;
      mem_addr   <= '0;
      refill_idx <= '0;
      refill_tag <= '0;
    end else begin
      state <= state_next;
      if (miss_start) begin
        mem_read   <= 1'b1;
        mem_addr   <= proc_addr[31 -: BADDR_W];
        refill_idx <= index;
        refill_tag <= tag;
      end else if (wr_en) begin
        mem_read <= 1'b0;
      end
    end
  end

endmodule
